// File: rtl/accum4_sched.sv
// rtl/accum4_sched.sv - burst scheduler sharing one accum4 accumulator between NREQ requesters
// Define ACCUM4_SCHED_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module accum4_sched #(
    parameter int NREQ      = 4,
    parameter int DW        = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    acc_en,
    output logic [DW-1:0]           acc_in_data,
    input  logic [DW-1:0]           acc_accum,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [DW-1:0]           res_sum,
    output logic [3:0]              res_beats
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESULT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] gnt;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic [IW-1:0] ptr;
    logic          found;
    logic [DW-1:0] base;
    logic [3:0]    count;
    logic [3:0]    count_inc;
    logic          beat;
    logic [DW-1:0] lane [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign lane[i] = req_data[i*DW +: DW];
    end

    assign count_inc = count + 4'd1;

`ifdef ACCUM4_SCHED_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IW'(NREQ - 1);
        end else if (state == RESULT && res_ready) begin
            ptr <= gnt;
        end
    end
`else
    // Scanning from NREQ-1 makes index 0 the first candidate every time.
    assign ptr = IW'(NREQ - 1);
`endif

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        acc_en      = 1'b0;
        acc_in_data = '0;
        res_valid   = 1'b0;
        beat        = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                req_ready[gnt] = 1'b1;
                beat           = req_valid[gnt];
                acc_en         = beat;
                if (beat) begin
                    acc_in_data = lane[gnt];
                    if (req_last[gnt] || count_inc == 4'(MAX_BURST)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The accumulator is never cleared here, so the burst sum is taken as a delta from base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            base      <= '0;
            count     <= '0;
            res_id    <= '0;
            res_sum   <= '0;
            res_beats <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        gnt   <= win;
                        base  <= acc_accum;
                        count <= '0;
                    end
                end
                BURST: begin
                    if (beat) begin
                        count <= count_inc;
                    end
                end
                DRAIN: begin
                    res_sum   <= acc_accum - base;
                    res_id    <= gnt;
                    res_beats <= count;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_accum4_sched.sv
// tb/tb_accum4_sched.sv - randomized self-checking bench for accum4_sched with a burst-level model
module tb_accum4_sched;
    localparam int NREQ      = 4;
    localparam int DW        = 4;
    localparam int MAX_BURST = 8;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               acc_en;
    logic [DW-1:0]      acc_in_data;
    logic [DW-1:0]      accum;
    logic               res_valid;
    logic               res_ready;
    logic [1:0]         res_id;
    logic [DW-1:0]      res_sum;
    logic [3:0]         res_beats;
    logic               acc_load;
    logic [DW-1:0]      load_val;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_exp  = 0;
    int n_got  = 0;
    logic [5:0]    q     [NREQ][$];
    logic [7:0]    exp_q [NREQ][$];
    logic [9:0]    got_q [$];
    logic [DW-1:0] m_sum [NREQ];
    int            m_cnt [NREQ];
    int            beat_cyc [$];
    logic [3:0]    beat_dat [$];
    int            res_rise [$];
    logic          prev_res_valid;

    accum4_sched #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .acc_en      (acc_en),
        .acc_in_data (acc_in_data),
        .acc_accum   (accum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_sum     (res_sum),
        .res_beats   (res_beats)
    );

    always #5 clk = ~clk;

    // Behavioural accum4: registered sum, updated the edge after en.
    always @(posedge clk) begin
        if (acc_load) accum <= load_val;
        else if (acc_en) accum <= accum + acc_in_data;
    end

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic cycle();
        logic [5:0] e;
        @(negedge clk);
        cyc++;
        if (acc_en) begin
            beat_cyc.push_back(cyc);
            beat_dat.push_back(acc_in_data);
        end
        if (res_valid && !prev_res_valid) res_rise.push_back(cyc);
        prev_res_valid = res_valid;
        if (res_valid && res_ready) begin
            got_q.push_back({res_id, res_beats, res_sum});
            n_got++;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() > 0) begin
                e = q[i][0];
                if (!e[5] || req_ready[i]) void'(q[i].pop_front());
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            e = (q[i].size() > 0) ? q[i][0] : 6'b0;
            req_valid[i]            = e[5];
            req_last[i]             = e[4];
            req_data[i*DW +: DW]    = e[3:0];
        end
    endtask

    task automatic push_beat(input int id, input logic [3:0] d, input logic last);
        q[id].push_back({1'b1, last, d});
        m_sum[id] = m_sum[id] + d;
        m_cnt[id]++;
        if (last || m_cnt[id] == MAX_BURST) begin
            exp_q[id].push_back({4'(m_cnt[id]), m_sum[id]});
            n_exp++;
            m_sum[id] = '0;
            m_cnt[id] = 0;
        end
    endtask

    task automatic push_gap(input int id, input int n);
        repeat (n) q[id].push_back(6'b0);
    endtask

    task automatic run(input int max, input string name);
        int n = 0;
        while (!(all_empty() && n_got == n_exp && !res_valid) && n < max) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s timeout: results got %0d required %0d", name, n_got, n_exp);
        end
    endtask

    task automatic clear_logs();
        beat_cyc.delete();
        beat_dat.delete();
        res_rise.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        acc_load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 7;
        if (req_ready !== 4'b0)   begin errors++; $display("FAIL reset_req_ready got %b required 0", req_ready); end
        if (acc_en !== 1'b0)      begin errors++; $display("FAIL reset_acc_en got %b required 0", acc_en); end
        if (acc_in_data !== 4'h0) begin errors++; $display("FAIL reset_acc_in_data got %h required 0", acc_in_data); end
        if (res_valid !== 1'b0)   begin errors++; $display("FAIL reset_res_valid got %b required 0", res_valid); end
        if (res_id !== 2'd0)      begin errors++; $display("FAIL reset_res_id got %0d required 0", res_id); end
        if (res_sum !== 4'h0)     begin errors++; $display("FAIL reset_res_sum got %h required 0", res_sum); end
        if (res_beats !== 4'd0)   begin errors++; $display("FAIL reset_res_beats got %0d required 0", res_beats); end
        rst_n = 1'b1;
        acc_load = 1'b0;
        cycle();
    endtask

    task automatic test_single_burst();
        logic [3:0] d [3] = '{4'h3, 4'h5, 4'h2};
        logic [9:0] g;
        int start;
        clear_logs();
        start = cyc;
        push_beat(0, 4'h3, 1'b0);
        push_beat(0, 4'h5, 1'b0);
        push_beat(0, 4'h2, 1'b1);
        run(50, "single");
        checks++;
        if (beat_cyc.size() != 3) begin
            errors++; $display("FAIL single_beats got %0d beats required 3", beat_cyc.size());
        end else begin
            checks += 5;
            if (beat_cyc[0] - start != 3) begin errors++; $display("FAIL single_grant_latency got %0d required 3", beat_cyc[0] - start); end
            if (beat_cyc[2] - beat_cyc[0] != 2) begin errors++; $display("FAIL single_consecutive span got %0d required 2", beat_cyc[2] - beat_cyc[0]); end
            for (int k = 0; k < 3; k++)
                if (beat_dat[k] !== d[k]) begin errors++; $display("FAIL single_data[%0d] got %h required %h", k, beat_dat[k], d[k]); end
            checks++;
            if (res_rise.size() != 1 || res_rise[0] != beat_cyc[2] + 2) begin
                errors++; $display("FAIL single_res_latency got %0d required %0d", (res_rise.size() > 0) ? res_rise[0] : -1, beat_cyc[2] + 2);
            end
        end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_results got %0d required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {2'd0, 4'd3, 4'hA}) begin
                errors++; $display("FAIL single_result got id=%0d beats=%0d sum=%h required id=0 beats=3 sum=a", g[9:8], g[7:4], g[3:0]);
            end
            void'(exp_q[0].pop_front());
        end
    endtask

    task automatic test_wrap();
        logic [9:0] g;
        push_beat(0, 4'h4, 1'b1);
        run(50, "wrap_pre");
        void'(got_q.pop_front());
        void'(exp_q[0].pop_front());
        checks++;
        if (accum !== 4'hE) begin errors++; $display("FAIL wrap_preload accum got %h required e", accum); end
        push_beat(1, 4'h3, 1'b0);
        push_beat(1, 4'h1, 1'b1);
        run(50, "wrap");
        checks += 2;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL wrap_results got %0d required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {2'd1, 4'd2, 4'h4}) begin
                errors++; $display("FAIL wrap_result got id=%0d beats=%0d sum=%h required id=1 beats=2 sum=4", g[9:8], g[7:4], g[3:0]);
            end
            void'(exp_q[1].pop_front());
        end
        if (accum !== 4'h2) begin errors++; $display("FAIL wrap_accum got %h required 2", accum); end
    endtask

    task automatic test_round_robin();
        logic [9:0] g;
        logic [7:0] e;
        int want;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_beat(0, 4'($urandom_range(15)), 1'b1);
            push_beat(2, 4'($urandom_range(15)), 1'b1);
        end
        run(200, "rr");
        checks++;
        if (got_q.size() != 8) begin errors++; $display("FAIL rr_results got %0d required 8", got_q.size()); end
        for (int k = 0; got_q.size() > 0; k++) begin
            g = got_q.pop_front();
`ifdef ACCUM4_SCHED_RR_EN
            want = (k % 2 == 0) ? 0 : 2;
`else
            want = (k < 4) ? 0 : 2;
`endif
            checks += 2;
            if (int'(g[9:8]) != want) begin errors++; $display("FAIL rr_order[%0d] got %0d required %0d", k, g[9:8], want); end
            if (exp_q[g[9:8]].size() == 0) begin
                errors++; $display("FAIL rr_sb unexpected result id=%0d", g[9:8]);
            end else begin
                e = exp_q[g[9:8]].pop_front();
                if (g[7:0] !== e) begin errors++; $display("FAIL rr_sb got beats=%0d sum=%h required beats=%0d sum=%h", g[7:4], g[3:0], e[7:4], e[3:0]); end
            end
        end
    endtask

    task automatic test_forced_end();
        logic [9:0] g;
        clear_logs();
        for (int k = 0; k < 10; k++) push_beat(3, 4'h1, k == 9);
        run(100, "forced");
        checks += 2;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL forced_results got %0d required 2", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {2'd3, 4'd8, 4'h8}) begin errors++; $display("FAIL forced_first got id=%0d beats=%0d sum=%h required id=3 beats=8 sum=8", g[9:8], g[7:4], g[3:0]); end
            void'(exp_q[3].pop_front());
            g = got_q.pop_front();
            if (g !== {2'd3, 4'd2, 4'h2}) begin errors++; $display("FAIL forced_second got id=%0d beats=%0d sum=%h required id=3 beats=2 sum=2", g[9:8], g[7:4], g[3:0]); end
            void'(exp_q[3].pop_front());
        end
        checks++;
        if (beat_cyc.size() != 10 || beat_cyc[8] - beat_cyc[7] != 4) begin
            errors++; $display("FAIL forced_regrant beats=%0d gap got %0d required 4", beat_cyc.size(), (beat_cyc.size() == 10) ? beat_cyc[8] - beat_cyc[7] : -1);
        end
    endtask

    task automatic test_gaps();
        logic [9:0] g;
        logic [7:0] e;
        clear_logs();
        push_beat(0, 4'($urandom_range(15)), 1'b0);
        push_beat(0, 4'($urandom_range(15)), 1'b0);
        push_gap(0, 3);
        push_beat(0, 4'($urandom_range(15)), 1'b1);
        run(60, "gaps");
        checks += 2;
        if (beat_cyc.size() != 3 || beat_cyc[2] - beat_cyc[1] != 4) begin
            errors++; $display("FAIL gaps_acc_en beats=%0d spacing got %0d required 4", beat_cyc.size(), (beat_cyc.size() == 3) ? beat_cyc[2] - beat_cyc[1] : -1);
        end
        if (got_q.size() != 1) begin
            errors++; $display("FAIL gaps_results got %0d required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q[0].pop_front();
            if (g !== {2'd0, e}) begin errors++; $display("FAIL gaps_sb got id=%0d beats=%0d sum=%h required id=0 beats=%0d sum=%h", g[9:8], g[7:4], g[3:0], e[7:4], e[3:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] g;
        logic [7:0] e;
        int n = 0;
        res_ready = 1'b0;
        push_beat(0, 4'($urandom_range(15)), 1'b0);
        push_beat(0, 4'($urandom_range(15)), 1'b1);
        cycle();
        cycle();
        push_beat(1, 4'($urandom_range(15)), 1'b1);
        while (!res_valid && n < 20) begin cycle(); n++; end
        e = exp_q[0][0];
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks += 2;
            if (res_valid !== 1'b1 || {res_id, res_beats, res_sum} !== {2'd0, e}) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b id=%0d beats=%0d sum=%h required valid=1 id=0 beats=%0d sum=%h", k, res_valid, res_id, res_beats, res_sum, e[7:4], e[3:0]);
            end
            if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b required 0", k, req_ready); end
        end
        res_ready = 1'b1;
        run(60, "bp");
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL bp_results[%0d] got none required id=%0d", k, k);
            end else begin
                g = got_q.pop_front();
                e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 8'hxx;
                if (g !== {2'(k), e}) begin errors++; $display("FAIL bp_sb[%0d] got id=%0d beats=%0d sum=%h required id=%0d beats=%0d sum=%h", k, g[9:8], g[7:4], g[3:0], k, e[7:4], e[3:0]); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] pre;
        logic [9:0] g;
        logic [7:0] e;
        int n = 0;
        clear_logs();
        pre = accum;
        for (int k = 0; k < 5; k++) q[0].push_back({1'b1, k == 4, 4'($urandom_range(15))});
        while (beat_cyc.size() < 2 && n < 20) begin cycle(); n++; end
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (req_ready !== 4'b0) begin errors++; $display("FAIL midrst_req_ready got %b required 0", req_ready); end
        if (acc_en !== 1'b0)    begin errors++; $display("FAIL midrst_acc_en got %b required 0", acc_en); end
        if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_res_valid got %b required 0", res_valid); end
        if (beat_dat.size() != 2 || accum !== 4'(pre + beat_dat[0] + beat_dat[1])) begin
            errors++; $display("FAIL midrst_accum got %h beats=%0d", accum, beat_dat.size());
        end
        q[0].delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        push_beat(1, 4'($urandom_range(15)), 1'b1);
        push_beat(0, 4'($urandom_range(15)), 1'b1);
        run(60, "midrst");
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL midrst_results[%0d] got none", k);
            end else begin
                g = got_q.pop_front();
                e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 8'hxx;
                if (g !== {2'(k), e}) begin errors++; $display("FAIL midrst_sb[%0d] got id=%0d beats=%0d sum=%h required id=%0d beats=%0d sum=%h", k, g[9:8], g[7:4], g[3:0], k, e[7:4], e[3:0]); end
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        res_ready = 1'b1;
        acc_load = 1'b0;
        load_val = '0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        prev_res_valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            m_sum[i] = '0;
            m_cnt[i] = 0;
        end
        test_reset();
        test_single_burst();
        test_wrap();
        test_round_robin();
        test_forced_end();
        test_gaps();
        test_backpressure();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
